pid_param: RTL

Parametrised successor to the ebike motor-drive PID controller. Converts a signed torque/cadence error into an unsigned, registered motor drive magnitude using decimated integral and derivative terms. Adds over the first-generation block: parametrised widths, gains and derivative span; a run-time mode select (OFF/P/PI/PID); conditional-integration anti-windup; a clean two-sided integrator clamp; a registered output; and an exported decimation tick. Sits between the error computation and the brushless commutation/PWM stage.

---
 rtl/pid_param_pkg.sv | 26 ++
 rtl/pid_decimator.sv | 28 ++
 rtl/pid_param.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pid_param_pkg.sv
// Shared types and helpers for the parametrised motor-drive PID controller.
package pid_param_pkg;

  typedef enum logic [1:0] {
    MODE_OFF = 2'b00,
    MODE_P   = 2'b01,
    MODE_PI  = 2'b10,
    MODE_PID = 2'b11
  } mode_e;

  // Clamp a signed value into the range of a signed number of the given width.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val, input int bits);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (bits - 1));
    if (val > hi) begin
      sat_signed = hi;
    end else if (val < lo) begin
      sat_signed = lo;
    end else begin
      sat_signed = val;
    end
  endfunction

endpackage

// File: rtl/pid_decimator.sv
// Free-running decimation counter; tick marks the all-ones count of the observed bits.
module pid_decimator
  import pid_param_pkg::*;
#(
  parameter int DECIM_W  = 20,
  parameter int FAST_SIM = 0
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  // Fast simulation watches only the low 15 bits so the tick period shrinks to 2^15.
  localparam int TICK_W = (FAST_SIM != 0 && DECIM_W > 15) ? 15 : DECIM_W;

  logic [DECIM_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DECIM_W'(1);
    end
  end

  assign tick = &cnt_reg[TICK_W-1:0];

endmodule

// File: rtl/pid_param.sv
// Motor-drive PID: signed error in, registered unsigned drive magnitude out,
// with integrator and derivative history advanced only on decimation ticks.
module pid_param
  import pid_param_pkg::*;
#(
  parameter int ERR_W    = 13,
  parameter int OUT_W    = 12,
  parameter int INT_FRAC = 5,
  parameter int D_SAT_W  = 9,
  parameter int D_SHIFT  = 1,
  parameter int D_DELAY  = 3,
  parameter int DECIM_W  = 20,
  parameter int FAST_SIM = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ERR_W-1:0] error,
  input  logic             not_pedaling,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] drv_mag,
  output logic             tick
);

  localparam int INT_W = OUT_W + INT_FRAC + 1;
  localparam int SUM_W = OUT_W + 2;
  localparam logic signed [SUM_W-1:0] SUM_HI  = SUM_W'((1 << OUT_W) - 1);
  localparam logic signed [INT_W:0]   INT_MAX = (INT_W + 1)'((1 << (INT_W - 1)) - 1);

  mode_e                    mode_q;
  logic signed [ERR_W-1:0]  err_s;
  logic                     use_i;
  logic                     use_d;
  logic [INT_W-1:0]         integ_reg;
  logic [INT_W-1:0]         integ_next;
  logic signed [INT_W:0]    integ_sum;
  logic [OUT_W-1:0]         drv_reg;
  logic [OUT_W-1:0]         drv_next;
  logic signed [ERR_W:0]    d_diff;
  logic signed [D_SAT_W-1:0] d_sat;
  logic signed [SUM_W-1:0]  p_term;
  logic signed [SUM_W-1:0]  i_term;
  logic signed [SUM_W-1:0]  d_term;
  logic signed [SUM_W-1:0]  sum;
  logic                     sat_hi;
  logic                     err_pos;
  logic [ERR_W-1:0]         hist_old;

  assign mode_q  = mode_e'(mode);
  assign err_s   = $signed(error);
  assign use_i   = (mode_q == MODE_PI) || (mode_q == MODE_PID);
  assign use_d   = (mode_q == MODE_PID);
  assign err_pos = !err_s[ERR_W-1] && (err_s != '0);

  pid_decimator #(
    .DECIM_W  (DECIM_W),
    .FAST_SIM (FAST_SIM)
  ) u_decim (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Error history: stage 0 holds the newest decimated sample.
  for (genvar gi = 0; gi < D_DELAY; gi++) begin : g_hist
    logic [ERR_W-1:0] stage_reg;
    logic [ERR_W-1:0] stage_in;
    if (gi == 0) begin : g_src
      assign stage_in = error;
    end else begin : g_src
      assign stage_in = g_hist[gi-1].stage_reg;
    end
    always_ff @(posedge clk) begin
      if (!rst_n || not_pedaling) begin
        stage_reg <= '0;
      end else if (tick) begin
        stage_reg <= stage_in;
      end
    end
  end

  assign hist_old = g_hist[D_DELAY-1].stage_reg;

  always_comb begin
    d_diff = $signed({err_s[ERR_W-1], err_s}) - $signed({hist_old[ERR_W-1], hist_old});
    d_sat  = D_SAT_W'(sat_signed(32'(d_diff), D_SAT_W));
    p_term = SUM_W'(err_s);
    i_term = use_i ? $signed({2'b00, integ_reg[INT_FRAC +: OUT_W]}) : '0;
    d_term = use_d ? (SUM_W'(d_sat) <<< D_SHIFT) : '0;
    sum    = p_term + i_term + d_term;
    sat_hi = (sum > SUM_HI);
    if (mode_q == MODE_OFF || sum[SUM_W-1]) begin
      drv_next = '0;
    end else if (sat_hi) begin
      drv_next = '1;
    end else begin
      drv_next = sum[OUT_W-1:0];
    end
  end

  // Integrator steps by the raw error and is clamped to the non-negative half range.
  always_comb begin
    integ_sum = $signed({1'b0, integ_reg}) + (INT_W + 1)'(err_s);
    if (integ_sum[INT_W]) begin
      integ_next = '0;
    end else if (integ_sum > INT_MAX) begin
      integ_next = INT_MAX[INT_W-1:0];
    end else begin
      integ_next = integ_sum[INT_W-1:0];
    end
  end

  // Anti-windup: a saturated output with a still-positive error freezes integration.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      integ_reg <= '0;
    end else if (not_pedaling || mode_q == MODE_OFF) begin
      integ_reg <= '0;
    end else if (tick && use_i && !(sat_hi && err_pos)) begin
      integ_reg <= integ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drv_reg <= '0;
    end else begin
      drv_reg <= drv_next;
    end
  end

  assign drv_mag = drv_reg;

endmodule
